// File: rtl/spu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spu_pkg
//  Description : Shared constants, register/address types and the write-back
//                port bundle used by the SPU register-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package spu_pkg;

  localparam int NUM_REGS = 128;
  localparam int DATA_W   = 128;
  localparam int ADDR_W   = 7;
  localparam int OP_W     = 11;
  localparam int IMM_W    = 18;
  localparam int FMT_W    = 3;

  // Big-endian bit numbering throughout the SPU datapath.
  typedef logic [0:DATA_W-1] reg_t;
  typedef logic [0:ADDR_W-1] raddr_t;

  typedef struct packed {
    reg_t   data;
    raddr_t addr;
    logic   en;
  } wb_port_t;

  // True when a write-back port is active and targets the given register.
  function automatic logic wb_hit(input wb_port_t p, input raddr_t a);
    return p.en && (p.addr == a);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_bypass_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rf_bypass_mux
//  Description : Combinational 3-way operand select. Returns odd write-back
//                data if it targets addr, else even write-back data if it
//                targets addr, else the supplied fallback value.
//  Ports       : wb_even, wb_odd - write-back ports (data/addr/en)
//                addr            - register address being read
//                fallback        - value used when no write-back matches
//                data            - selected operand
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_bypass_mux
  import spu_pkg::*;
(
  input  wb_port_t wb_even,
  input  wb_port_t wb_odd,
  input  raddr_t   addr,
  input  reg_t     fallback,
  output reg_t     data
);

  always_comb begin
    data = fallback;
    if (wb_hit(wb_odd, addr))
      data = wb_odd.data;
    else if (wb_hit(wb_even, addr))
      data = wb_even.data;
  end

endmodule
`default_nettype wire

// File: rtl/register_table.sv
`default_nettype none
// ============================================================================
//  Module      : register_table
//  Description : SPU register-fetch stage. 128 x 128-bit register file with
//                even/odd write-back ports, bypassed three-operand read and
//                the RF/FWD pipeline register feeding the execution pipes.
//  Ports       : clk, reset (async, active-high), stall
//                *_in              - decoded instruction fields / addresses
//                *_wb_even/_wb_odd - write-back data, address, enable
//                op, format, rt_addr, imm, reg_write, ra, rb, rt_st
//                                  - registered RF/FWD outputs
//                wb_conflict       - sticky same-address dual write flag
//  Revision    : 1.0 - initial release
// ============================================================================
module register_table
  import spu_pkg::*;
#(
  parameter int NUM_REGS_P = spu_pkg::NUM_REGS,
  parameter int DATA_W_P   = spu_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [0:OP_W-1]     op_in,
  input  logic [FMT_W-1:0]    format_in,
  input  logic [0:ADDR_W-1]   rt_addr_in,
  input  logic [0:ADDR_W-1]   ra_addr_in,
  input  logic [0:ADDR_W-1]   rb_addr_in,
  input  logic [0:IMM_W-1]    imm_in,
  input  logic                reg_write_in,
  input  logic [0:DATA_W_P-1] rt_wb_even,
  input  logic [0:ADDR_W-1]   rt_addr_wb_even,
  input  logic                reg_write_wb_even,
  input  logic [0:DATA_W_P-1] rt_wb_odd,
  input  logic [0:ADDR_W-1]   rt_addr_wb_odd,
  input  logic                reg_write_wb_odd,
  output logic [0:OP_W-1]     op,
  output logic [FMT_W-1:0]    format,
  output logic [0:ADDR_W-1]   rt_addr,
  output logic [0:DATA_W_P-1] ra,
  output logic [0:DATA_W_P-1] rb,
  output logic [0:DATA_W_P-1] rt_st,
  output logic [0:IMM_W-1]    imm,
  output logic                reg_write,
  output logic                wb_conflict
);

  localparam int NUM_RD = 3;  // read ports: 0 = ra, 1 = rb, 2 = rt_st

  reg_t     regs [0:NUM_REGS_P-1];
  wb_port_t wb_even;
  wb_port_t wb_odd;

  raddr_t   rd_addr_in  [0:NUM_RD-1];
  raddr_t   rd_addr_q   [0:NUM_RD-1];
  reg_t     rd_q        [0:NUM_RD-1];
  raddr_t   rd_addr_sel [0:NUM_RD-1];
  reg_t     rd_fallback [0:NUM_RD-1];
  reg_t     rd_next     [0:NUM_RD-1];

  assign wb_even = '{data: rt_wb_even, addr: rt_addr_wb_even, en: reg_write_wb_even};
  assign wb_odd  = '{data: rt_wb_odd,  addr: rt_addr_wb_odd,  en: reg_write_wb_odd};

  assign rd_addr_in[0] = ra_addr_in;
  assign rd_addr_in[1] = rb_addr_in;
  assign rd_addr_in[2] = rt_addr_in;

  // Register array. Odd port is written last so it wins on an address clash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS_P; i++)
        regs[i] <= '0;
    end else begin
      if (wb_even.en)
        regs[wb_even.addr] <= wb_even.data;
      if (wb_odd.en)
        regs[wb_odd.addr] <= wb_odd.data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wb_conflict <= 1'b0;
    else if (wb_even.en && wb_odd.en && (wb_even.addr == wb_odd.addr))
      wb_conflict <= 1'b1;
  end

  // One bypass mux per read port. While stalled the mux looks at the latched
  // address and falls back to the held operand, so only a matching
  // write-back can change the output; otherwise it reads the array.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_read
    assign rd_addr_sel[g] = stall ? rd_addr_q[g] : rd_addr_in[g];
    assign rd_fallback[g] = stall ? rd_q[g]      : regs[rd_addr_in[g]];

    rf_bypass_mux u_mux (
      .wb_even  (wb_even),
      .wb_odd   (wb_odd),
      .addr     (rd_addr_sel[g]),
      .fallback (rd_fallback[g]),
      .data     (rd_next[g])
    );

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rd_q[g]      <= '0;
        rd_addr_q[g] <= '0;
      end else begin
        rd_q[g] <= rd_next[g];
        if (!stall)
          rd_addr_q[g] <= rd_addr_in[g];
      end
    end
  end

  assign ra    = rd_q[0];
  assign rb    = rd_q[1];
  assign rt_st = rd_q[2];

  // Decoded instruction fields; nops pass through like any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op        <= '0;
      format    <= '0;
      rt_addr   <= '0;
      imm       <= '0;
      reg_write <= 1'b0;
    end else if (!stall) begin
      op        <= op_in;
      format    <= format_in;
      rt_addr   <= rt_addr_in;
      imm       <= imm_in;
      reg_write <= reg_write_in;
    end
  end

endmodule
`default_nettype wire

// File: doc/register_table.md
Name: register_table

Overview:
- Register-fetch (RF) stage of the SPU. It sits directly upstream of the odd-pipe local store and the even-pipe execution units.
- Holds the 128 x 128-bit architectural register file and accepts two write-back ports, one from the even pipe and one from the odd pipe.
- Reads three operands per instruction (ra, rb, rt_st). Write-back data is bypassed into those reads.
- Registers the decoded instruction fields and operands into the RF/FWD pipeline register that drives the execution pipes.

Parameters:
- NUM_REGS, 128, number of architectural registers (address width 7).
- DATA_W, 128, register width in bits (big-endian numbering [0:DATA_W-1]).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- stall  in  1  holds the RF/FWD pipeline register.
- op_in  in  [0:10]  decoded opcode, truncated per format.
- format_in  in  [2:0]  instruction format.
- rt_addr_in  in  [0:6]  destination / store-source register address.
- ra_addr_in  in  [0:6]  source A address.
- rb_addr_in  in  [0:6]  source B address.
- imm_in  in  [0:17]  immediate.
- reg_write_in  in  1  instruction writes the register file.
- rt_wb_even  in  [0:127]  even-pipe write-back data.
- rt_addr_wb_even  in  [0:6]  even-pipe write-back address.
- reg_write_wb_even  in  1  even-pipe write enable.
- rt_wb_odd  in  [0:127]  odd-pipe write-back data.
- rt_addr_wb_odd  in  [0:6]  odd-pipe write-back address.
- reg_write_wb_odd  in  1  odd-pipe write enable.
- op  out  [0:10]  registered opcode.
- format  out  [2:0]  registered format.
- rt_addr  out  [0:6]  registered destination address.
- ra  out  [0:127]  registered operand A.
- rb  out  [0:127]  registered operand B.
- rt_st  out  [0:127]  registered store operand, read at rt_addr_in.
- imm  out  [0:18-1]  registered immediate.
- reg_write  out  1  registered write flag.
- wb_conflict  out  1  sticky flag: both write ports targeted the same address in one cycle.

Behaviour:
- Reset:
  - Asynchronous and active-high. While asserted, every output is 0, all 128 registers are 0, and the latched source addresses are 0.
  - Reset mid-operation discards any in-flight write-back and pipeline contents.
- Write-back:
  - On each rising edge, if reg_write_wb_even=1 the register at rt_addr_wb_even is written; likewise for the odd port.
  - If both ports are enabled and the addresses are equal, the odd data is written and wb_conflict is set to 1.
  - wb_conflict stays set until reset.
  - Register 0 is an ordinary register, with no hardwired value.
- Read with bypass, latency 1 cycle (stall=0):
  - At the rising edge, each of ra/rb/rt_st is loaded from the value visible that cycle.
  - Priority for that value: odd write-back matching the address > even write-back matching the address > array contents.
  - op/format/rt_addr/imm/reg_write are loaded from the *_in ports at the same edge.
  - The ra_addr_in/rb_addr_in/rt_addr_in values are latched internally for stall refresh.
- Stall (stall=1):
  - op, format, rt_addr, imm and reg_write hold their values. Latched addresses hold.
  - ra, rb and rt_st hold, except when a write-back in that cycle matches the latched address. In that case the output is refreshed with the write-back data, using the same odd > even priority.
  - Write-back into the array proceeds regardless of stall.
- Bubble:
  - The upstream stage presents format_in=0, op_in=0, reg_write_in=0 to insert a nop.
  - This block passes a nop through like any other instruction; there is no special case.
- Width rules: addresses are 7 bits, so no wrap or overflow case exists. Data is passed bit-exact with no sign extension.

Decomposition:
- Shared package spu_pkg holds:
  - constants NUM_REGS, DATA_W, ADDR_W=7, OP_W=11, IMM_W=18, FMT_W=3;
  - typedef reg_t (logic [0:127]) and typedef raddr_t (logic [0:6]);
  - a struct wb_port_t {data, addr, en} for the write-back ports.
- One sub-module, rf_bypass_mux: a combinational 3-way select (odd wb / even wb / array) instantiated once per read port.
- Array, pipeline register and stall refresh logic stay in register_table.

Test Plan:
- Reset: assert reset mid-run with wb enables high -> all outputs 0 immediately, wb_conflict=0. Afterwards, reading r5 returns 0.
- Write then read: odd wb r5=128'hA5..A5 at cycle 0; ra_addr_in=5 at cycle 1 -> ra=128'hA5..A5 after the cycle-1 edge.
- Same-cycle bypass: even wb r7=128'h1234 and rb_addr_in=7 in the same cycle -> rb=128'h1234 one edge later.
- Conflict: even wb r9=128'h1 and odd wb r9=128'h2 in the same cycle -> r9 reads 128'h2 and wb_conflict=1, staying set for 10 further cycles.
- Stall refresh: load ra_addr 3 (value 0), raise stall, odd wb r3=128'hFF -> ra=128'hFF on the next edge while op/imm hold. Drop stall -> the next instruction loads normally.
- Store operand: rt_addr_in=12 holding 128'hDEAD, format_in=0, op_in=11'b00101000100, reg_write_in=0 -> rt_st=128'hDEAD, op and rt_addr=12 registered, reg_write=0.
